eth_frame_tx8: RTL
==================

# eth_frame_tx8

Byte-wide Ethernet II transmit framer that sits directly downstream of the 8-bit IP header encoder in the UDP transmit path. On a start pulse it loads the IP encoder and emits preamble, SFD, MAC header and EtherType onto a GMII-style byte interface. It then pulls the IP datagram byte-by-byte from the encoder with a run strobe, zero-pads to the 46-byte minimum payload, and appends the CRC-32 FCS. A mandatory inter-frame gap follows before the next frame is accepted.

## Interface
- MAX_PAYLOAD, 1500, largest payload in bytes; larger lengths are clamped.
- MIN_PAYLOAD, 46, payload bytes below which zero padding is added.
- IFG_CYCLES, 12, idle cycles after the FCS before a new start is accepted.
- ETHERTYPE, 16'h0800, EtherType field value.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send a frame; sampled only in IDLE.
- payload_length  in  16  IP total length in bytes; latched on accepted start.
- dst_mac  in  48  destination MAC; latched on accepted start; byte [47:40] is sent first.
- src_mac  in  48  source MAC; latched on accepted start.
- ip_data  in  8  current byte from the IP encoder's data_out.
- ip_load  out  1  one-cycle pulse that drives the encoder's sync_reset to load its header.
- ip_run  out  1  advances the encoder by one byte.
- txd  out  8  transmit byte, registered.
- tx_en  out  1  high for every byte from the first preamble byte through the last FCS byte, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the cycle the IFG ends.

## Operation
- States are IDLE, PRE, HDR, PAY, PAD, FCS, IFG. An 11-bit byte counter is cleared on every state entry.
- IDLE:
  - start=1 latches the MACs and len = min(payload_length, MAX_PAYLOAD).
  - ip_load is asserted in the same cycle.
  - The state moves to PRE.
- PRE: 8 bytes, 0x55 ×7 then 0xD5.
- HDR: 14 bytes, in order dst_mac, src_mac, ETHERTYPE (high byte first).
- PAY:
  - Runs for len bytes. Each cycle txd takes ip_data and ip_run=1 in that same cycle.
  - len=0 skips PAY.
- PAD: runs for max(0, MIN_PAYLOAD − len) bytes of 0x00.
- FCS:
  - Covers HDR+PAY+PAD bytes.
  - Polynomial 0x04C11DB7, reflected, initial value 0xFFFFFFFF, final value complemented.
  - Sent as 4 bytes: ~crc[7:0] first, then ~crc[15:8], ~crc[23:16], ~crc[31:24].
- IFG: IFG_CYCLES cycles with tx_en=0 and txd=0. done pulses in the last cycle, then the state returns to IDLE.
- ip_run is 0 outside PAY. ip_load is 0 except on the accepting cycle.
- start is ignored while busy. No queueing is done.

## Timing
- Reset (asynchronous, immediate): state=IDLE, txd=0x00, tx_en=0, ip_load=0, ip_run=0, busy=0, done=0, CRC=0xFFFFFFFF, counter=0.
- Reset asserted mid-frame aborts the frame at once: tx_en drops with no FCS, and the encoder is not run further.
- Start accepted at edge N:
  - First 0x55 appears on txd with tx_en=1 after edge N+1.
  - busy is high from N+1.
- Frame length on the wire is 8 + 14 + max(len, 46) + 4 cycles. Minimum is 72; the maximum at len 1500 is 1526.
- Encoder handshake:
  - ip_load at cycle N gives valid ip_data (0x45) from N+1 and holds it until the first ip_run.
  - ip_data is sampled in the cycle ip_run is high.
  - Exactly len ip_run pulses occur per frame.
- Back-to-back frames: minimum start-to-start spacing is frame length + IFG_CYCLES + 1 cycles.
- start asserted in the same cycle as done is ignored. It is accepted on the following IDLE cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold reset_n=0, release it, then drive no start.
  - Required: txd=0, tx_en=0, busy=0, and no ip_load or ip_run for 100 cycles.
- Minimum frame:
  - Stimulus: len=20 with a model encoder. dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01.
  - Required: 8 preamble bytes and the header, then 20 IP bytes and 26 zero pad bytes.
  - Required: a 4-byte FCS equal to software CRC-32; the CRC is verified with check value 0xCBF43926 for "123456789". Exactly 72 tx_en cycles and 20 ip_run pulses.
- No padding:
  - Stimulus: len=46 and len=1500.
  - Required: no pad bytes, and tx_en lasts 72 and 1526 cycles respectively.
- Clamp:
  - Stimulus: payload_length=2000.
  - Required: 1500 ip_run pulses and 1526 tx_en cycles.
- Busy and back-to-back:
  - Stimulus: a second start mid-frame, and another in the done cycle.
  - Required: both are ignored, and exactly 12 idle cycles follow the FCS.
  - Required: a start one cycle after done is accepted.
- Abort:
  - Stimulus: drop reset_n during PAY byte 10.
  - Required: tx_en=0 immediately and the state is IDLE. The next full frame is correct.

Source files
------------

// File: rtl/eth_frame_tx8.sv
// Byte-wide Ethernet II transmit framer.
// Emits preamble/SFD, MAC header and EtherType, then pulls the IP datagram
// from the upstream 8-bit header encoder, zero-pads to the minimum payload,
// appends the CRC-32 FCS and enforces an inter-frame gap.
// txd/tx_en are registered, so the wire lags the state by one cycle.
// ip_load/ip_run are decoded combinationally so that the encoder sees them
// in the same cycle the byte is taken.
module eth_frame_tx8 #(
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          IFG_CYCLES  = 12,
    parameter logic [15:0] ETHERTYPE   = 16'h0800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] payload_length,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [7:0]  ip_data,
    output logic        ip_load,
    output logic        ip_run,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_PAY  = 3'd3,
        S_PAD  = 3'd4,
        S_FCS  = 3'd5,
        S_IFG  = 3'd6
    } state_t;

    localparam logic [15:0] MAX_LEN16 = 16'(MAX_PAYLOAD);
    localparam logic [10:0] MAX_LEN   = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_LEN   = 11'(MIN_PAYLOAD);
    localparam logic [10:0] IFG_LAST  = 11'(IFG_CYCLES - 1);
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    // Reflected CRC-32 (poly 0x04C11DB7, reversed form 0xEDB88320), one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        ip_load_s;
    logic        ip_run_s;
    logic [10:0] pad_len_s;
    logic [111:0] hdr_s;
    logic [3:0]  hdr_idx_s;
    logic [7:0]  hdr_byte_s;
    logic [31:0] fcs_s;
    logic [7:0]  fcs_byte_s;

    // Header bytes, FCS byte selection and pad length derived from latched fields.
    always_comb begin
        hdr_s      = {dst_q, src_q, ETHERTYPE};
        hdr_idx_s  = 4'd13 - cnt_q[3:0];
        hdr_byte_s = hdr_s[{hdr_idx_s, 3'b000} +: 8];
        fcs_s      = ~crc_q;
        fcs_byte_s = fcs_s[{cnt_q[1:0], 3'b000} +: 8];
        if (len_q < MIN_LEN) begin
            pad_len_s = MIN_LEN - len_q;
        end else begin
            pad_len_s = 11'd0;
        end
    end

    // Next-state, next-output and CRC accumulation for the framer FSM.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        dst_d     = dst_q;
        src_d     = src_q;
        crc_d     = crc_q;
        txd_d     = 8'h00;
        tx_en_d   = 1'b0;
        ip_load_s = 1'b0;
        ip_run_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                crc_d = CRC_INIT;
                if (start) begin
                    dst_d     = dst_mac;
                    src_d     = src_mac;
                    len_d     = (payload_length > MAX_LEN16) ? MAX_LEN : payload_length[10:0];
                    ip_load_s = 1'b1;
                    state_d   = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == 11'd7) begin
                    txd_d   = 8'hD5;
                    state_d = S_HDR;
                end else begin
                    txd_d = 8'h55;
                end
            end
            S_HDR: begin
                tx_en_d = 1'b1;
                txd_d   = hdr_byte_s;
                crc_d   = crc32_byte(crc_q, hdr_byte_s);
                if (cnt_q == 11'd13) begin
                    if (len_q != 11'd0) begin
                        state_d = S_PAY;
                    end else if (pad_len_s != 11'd0) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FCS;
                    end
                end else begin
                    state_d = S_HDR;
                end
            end
            S_PAY: begin
                tx_en_d  = 1'b1;
                ip_run_s = 1'b1;
                txd_d    = ip_data;
                crc_d    = crc32_byte(crc_q, ip_data);
                if (cnt_q == len_q - 11'd1) begin
                    state_d = (pad_len_s != 11'd0) ? S_PAD : S_FCS;
                end else begin
                    state_d = S_PAY;
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h00;
                crc_d   = crc32_byte(crc_q, 8'h00);
                if (cnt_q == pad_len_s - 11'd1) begin
                    state_d = S_FCS;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_byte_s;
                if (cnt_q == 11'd3) begin
                    state_d = S_IFG;
                end else begin
                    state_d = S_FCS;
                end
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_IFG;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Byte counter restarts from zero on every state entry.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = 11'd0;
        end else begin
            cnt_d = cnt_q + 11'd1;
        end

        // busy/done are registered look-ahead decodes of the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_IFG) && (cnt_d == IFG_LAST);
    end

    // State, datapath and output registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 11'd0;
            len_q   <= 11'd0;
            dst_q   <= 48'h0000_0000_0000;
            src_q   <= 48'h0000_0000_0000;
            crc_q   <= CRC_INIT;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ip_load = ip_load_s;
    assign ip_run  = ip_run_s;
    assign txd     = txd_q;
    assign tx_en   = tx_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
